pulse_event_stamp: RTL and testbench

//  Fast-domain consumer of the one-cycle event pulse produced by the slow-to-fast

---
 rtl/pulse_event_stamp.sv | 99 +++++++++
 tb/tb_pulse_event_stamp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_stamp.sv
// pulse_event_stamp: timestamps fast-domain event pulses against a free-running counter
// and buffers the stamps in a show-ahead FIFO. Define PES_DELTA_EN to store inter-event deltas.
module pulse_event_stamp #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   evt_pulse,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [TS_W-1:0]   ts_cnt;
    logic [TS_W-1:0]   stamp;
    logic [TS_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    // Outputs depend only on registered state, so out_ready never reaches out_valid/out_ts.
    assign out_valid = (level != '0);
    assign out_ts    = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = evt_pulse & ((level != FULL_LEVEL) | pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

`ifdef PES_DELTA_EN
    logic [TS_W-1:0] ts_prev;

    // Dropped events also advance ts_prev, so a delta is always time since the previous event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_prev <= '0;
        end else if (evt_pulse) begin
            ts_prev <= ts_cnt;
        end
    end

    assign stamp = ts_cnt - ts_prev;
`else
    assign stamp = ts_cnt;
`endif

    // NOTE: storage array has no reset; contents are only observable through out_valid-qualified reads.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= stamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr wins, so no overflow is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (evt_pulse && !push) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_event_stamp.sv
// Scoreboard bench for pulse_event_stamp: directed pulses push expected stamps,
// a negedge monitor compares every popped head against the queue.
module tb_pulse_event_stamp;

    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             evt_pulse = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             out_valid;
    logic             ovf;
    logic [TS_W-1:0]  out_ts;
    logic [LVL_W-1:0] level;

    int checks   = 0;
    int failures = 0;

    logic [TS_W-1:0] exp_q[$];
    logic [TS_W-1:0] tb_ts;
    logic [TS_W-1:0] m_prev = '0;

    pulse_event_stamp #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt_pulse (evt_pulse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Cycle reference: value the DUT counter should hold during the current cycle.
    always @(posedge clk) tb_ts <= rst ? '0 : tb_ts + 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TS_W-1:0] t, input bit accepted);
        logic [TS_W-1:0] v;
`ifdef PES_DELTA_EN
        v = t - m_prev;
`else
        v = t;
`endif
        m_prev = t;
        if (accepted) exp_q.push_back(v);
    endtask

    task automatic wait_ts(input logic [TS_W-1:0] t);
        int n;
        n = 0;
        while (tb_ts !== t && n < 70000) begin
            tick();
            n++;
        end
        if (tb_ts !== t) begin
            checks++;
            failures++;
            $display("FAIL wait_ts: ts=%0d target=%0d", tb_ts, t);
        end
    endtask

    task automatic pulse_at(input logic [TS_W-1:0] t, input bit accepted);
        wait_ts(t);
        evt_pulse = 1'b1;
        issue(t, accepted);
        tick();
        evt_pulse = 1'b0;
    endtask

    task automatic reset_dut(input int cycles);
        rst = 1'b1;
        exp_q.delete();
        m_prev = '0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (level !== '0 && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check({name, "_valid_after_drain"}, 32'(out_valid), 32'd0);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a pop happens at the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(out_ts), 32'hFFFF_FFFF);
            end else begin
                check("pop_ts", 32'(out_ts), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // 1: reset state, single stamp, show-ahead stability
        reset_dut(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        pulse_at(16'd5, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_level", 32'(level), 32'd1);
        check("t1_ts", 32'(out_ts), 32'd5);
        repeat (3) tick();
        check("t1_hold_valid", 32'(out_valid), 32'd1);
        check("t1_hold_level", 32'(level), 32'd1);
        check("t1_hold_ts", 32'(out_ts), 32'd5);
        drain("t1");

        // 2: fill to DEPTH, fifth event dropped and sets sticky ovf
        reset_dut(1);
        pulse_at(16'd10, 1'b1);
        pulse_at(16'd12, 1'b1);
        pulse_at(16'd14, 1'b1);
        pulse_at(16'd16, 1'b1);
        pulse_at(16'd18, 1'b0);
        check("t2_level", 32'(level), 32'd4);
        check("t2_ovf", 32'(ovf), 32'd1);
        drain("t2");
        check("t2_ovf_sticky", 32'(ovf), 32'd1);

        // 3: push and pop in the same cycle while full
        reset_dut(1);
        pulse_at(16'd20, 1'b1);
        pulse_at(16'd22, 1'b1);
        pulse_at(16'd24, 1'b1);
        pulse_at(16'd26, 1'b1);
        check("t3_full", 32'(level), 32'd4);
        wait_ts(16'd30);
        evt_pulse = 1'b1;
        out_ready = 1'b1;
        issue(16'd30, 1'b1);
        tick();
        evt_pulse = 1'b0;
        out_ready = 1'b0;
        check("t3_level", 32'(level), 32'd4);
        check("t3_ovf", 32'(ovf), 32'd0);
        drain("t3");

        // 6: set beats clear, then clear alone
        reset_dut(1);
        pulse_at(16'd10, 1'b1);
        pulse_at(16'd12, 1'b1);
        pulse_at(16'd14, 1'b1);
        pulse_at(16'd16, 1'b1);
        check("t6_ovf_pre", 32'(ovf), 32'd0);
        wait_ts(16'd20);
        evt_pulse = 1'b1;
        ovf_clr = 1'b1;
        issue(16'd20, 1'b0);
        tick();
        evt_pulse = 1'b0;
        check("t6_ovf_set_wins", 32'(ovf), 32'd1);
        tick();
        ovf_clr = 1'b0;
        check("t6_ovf_cleared", 32'(ovf), 32'd0);
        check("t6_level", 32'(level), 32'd4);
        drain("t6");

        // 5: reset mid-operation with level=3 and ovf=1
        reset_dut(1);
        pulse_at(16'd10, 1'b1);
        pulse_at(16'd12, 1'b1);
        pulse_at(16'd14, 1'b1);
        pulse_at(16'd16, 1'b1);
        pulse_at(16'd18, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_level_pre", 32'(level), 32'd3);
        check("t5_ovf_pre", 32'(ovf), 32'd1);
        reset_dut(1);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_ovf", 32'(ovf), 32'd0);
        evt_pulse = 1'b1;
        issue(16'd0, 1'b1);
        tick();
        issue(16'd1, 1'b1);
        tick();
        evt_pulse = 1'b0;
        check("t5_level_post", 32'(level), 32'd2);
        drain("t5");

        // 4: counter wrap (delta build: 65535 then 3)
        reset_dut(1);
        pulse_at(16'd65535, 1'b1);
        pulse_at(16'd2, 1'b1);
        check("t4_level", 32'(level), 32'd2);
        check("t4_ovf", 32'(ovf), 32'd0);
        drain("t4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
